// File: rtl/stage_fifo.sv
// stage_fifo: DEPTH-entry credit/ready link buffer.
// Registered-only outputs with optional full-rate pass-through credit.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module stage_fifo #(
  parameter int ID        = 0,
  parameter int EDGE      = 0,
  parameter int DEPTH     = 2,
  parameter int WIDTH     = `DATA_WIDTH + 1,
  parameter int PASS_FULL = 0,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ready_in,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             credit_out,
  input  logic             credit_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             flush,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);
  localparam logic          PF    = (PASS_FULL != 0);

  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             mem_v [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign full  = (cnt == FULLC);
  assign empty = (cnt == '0);

  // PASS_FULL adds a combinational credit_in -> credit_out path
  assign credit_out = ~full | (PF & credit_in);

  assign push = ready_in & credit_out;
  assign pop  = ~empty & credit_in;

  assign ready_out = ~empty;
  assign data_out  = empty ? '0 : mem_d[rd_ptr];
  assign valid_out = empty ? 1'b0 : mem_v[rd_ptr];
  assign count     = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] <= '0;
        mem_v[i] <= 1'b0;
      end
    end else if (flush) begin
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      // when full with PASS_FULL, wr_ptr == rd_ptr: the slot is read before it is overwritten
      if (push) begin
        mem_d[wr_ptr] <= data_in;
        mem_v[wr_ptr] <= valid_in;
        wr_ptr        <= nxt(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      if (push && !pop) begin
        cnt <= cnt + CW'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_stage_fifo.sv
// tb_stage_fifo: four stage_fifo configurations on shared stimulus,
// checked against a queue-style model plus directed vectors.
module tb_stage_fifo;

  localparam int W = 8;
  localparam int N = 4;
  localparam int DEPS [N] = '{4, 2, 1, 3};
  localparam int PFS  [N] = '{0, 1, 0, 0};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ready_in = 1'b0;
  logic         valid_in = 1'b0;
  logic         credit_in = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] data_in = '0;

  logic         co [N];
  logic         ro [N];
  logic         vo [N];
  logic [W-1:0] dout [N];
  logic [4:0]   cnt [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int CWG = $clog2(DEPS[g] + 1);
    logic [CWG-1:0] c;
    stage_fifo #(
      .ID(g), .EDGE(g), .DEPTH(DEPS[g]),
      .WIDTH(W), .PASS_FULL(PFS[g])
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .ready_in(ready_in), .valid_in(valid_in),
      .data_in(data_in), .credit_out(co[g]),
      .credit_in(credit_in), .ready_out(ro[g]),
      .data_out(dout[g]), .valid_out(vo[g]),
      .flush(flush), .count(c)
    );
    assign cnt[g] = 5'(c);
  end

  int vecs = 0;
  int misc = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // model: each link is an ordered list of {valid,data}, head at index 0
  int         mc [N];
  logic [W:0] mq [N][17];

  function automatic bit mcredit(int i);
    return (mc[i] != DEPS[i]) || (PFS[i] != 0 && credit_in);
  endfunction

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      if (!rst_n || flush) begin
        mc[i] = 0;
      end else begin
        bit pu, po;
        pu = ready_in && mcredit(i);
        po = (mc[i] != 0) && credit_in;
        if (po) begin
          for (int j = 0; j < 16; j++) mq[i][j] = mq[i][j+1];
          mc[i]--;
        end
        if (pu) begin
          mq[i][mc[i]] = {valid_in, data_in};
          mc[i]++;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      logic [W:0] h;
      h = (mc[i] != 0) ? mq[i][0] : '0;
      chk($sformatf("ready_out[%0d]", i), ro[i], mc[i] != 0);
      chk($sformatf("count[%0d]", i), cnt[i], mc[i]);
      chk($sformatf("data_out[%0d]", i), dout[i], h[W-1:0]);
      chk($sformatf("valid_out[%0d]", i), vo[i], h[W]);
      chk($sformatf("credit_out[%0d]", i), co[i], mcredit(i));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  typedef struct {
    logic         f, ri, vi;
    logic [W-1:0] d;
    logic         ci, ero, eco;
    int           ecnt;
    logic [W-1:0] edout;
  } vec_t;

  function automatic vec_t mk(bit f, bit ri, bit vi, int d, bit ci,
                              bit ero, bit eco, int ecnt, int edout);
    vec_t v;
    v.f = f; v.ri = ri; v.vi = vi; v.d = W'(d); v.ci = ci;
    v.ero = ero; v.eco = eco; v.ecnt = ecnt; v.edout = W'(edout);
    return v;
  endfunction

  vec_t tv [13];

  initial begin
    int p1, p2;
    logic [W:0] wexp [5];
    logic [W:0] wgot [5];
    int nw;

    tv[0]  = mk(0, 1, 1, 'h11, 0, 1, 1, 1, 'h11);
    tv[1]  = mk(0, 1, 0, 'h22, 0, 1, 1, 2, 'h11);
    tv[2]  = mk(0, 1, 1, 'h33, 0, 1, 1, 3, 'h11);
    tv[3]  = mk(0, 1, 1, 'h44, 0, 1, 0, 4, 'h11);
    tv[4]  = mk(0, 1, 1, 'h55, 0, 1, 0, 4, 'h11);
    tv[5]  = mk(0, 0, 0, 'h00, 1, 1, 1, 3, 'h22);
    tv[6]  = mk(0, 0, 0, 'h00, 1, 1, 1, 2, 'h33);
    tv[7]  = mk(0, 0, 0, 'h00, 1, 1, 1, 1, 'h44);
    tv[8]  = mk(0, 0, 0, 'h00, 1, 0, 1, 0, 'h00);
    tv[9]  = mk(0, 0, 0, 'h00, 1, 0, 1, 0, 'h00);
    tv[10] = mk(0, 1, 1, 'h66, 1, 1, 1, 1, 'h66);
    tv[11] = mk(0, 1, 1, 'h77, 1, 1, 1, 1, 'h77);
    tv[12] = mk(1, 1, 1, 'h88, 1, 0, 1, 0, 'h00);

    for (int i = 0; i < N; i++) mc[i] = 0;

    cycle();
    chk("reset credit_out", co[0], 1'b1);
    rst_n = 1'b1;

    for (int k = 0; k < 13; k++) begin
      flush = tv[k].f; ready_in = tv[k].ri; valid_in = tv[k].vi;
      data_in = tv[k].d; credit_in = tv[k].ci;
      cycle();
      chk($sformatf("tv%0d ready_out", k), ro[0], tv[k].ero);
      chk($sformatf("tv%0d credit_out", k), co[0], tv[k].eco);
      chk($sformatf("tv%0d count", k), cnt[0], tv[k].ecnt);
      chk($sformatf("tv%0d data_out", k), dout[0], tv[k].edout);
    end
    flush = 1'b0;

    // flushed word 0x88 must never appear
    ready_in = 1'b0; credit_in = 1'b1;
    cycle();
    chk("post-flush ready_out", ro[0], 1'b0);

    // async reset with two words held
    ready_in = 1'b1; credit_in = 1'b0; data_in = 8'h5a;
    cycle();
    data_in = 8'h5b;
    cycle();
    chk("pre-reset count", cnt[0], 2);
    ready_in = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) mc[i] = 0;
    chk("async rst ready_out", ro[0], 1'b0);
    chk("async rst credit_out", co[0], 1'b1);
    chk("async rst count", cnt[0], 0);
    chk("async rst data_out", dout[0], 0);
    chk("async rst valid_out", vo[0], 0);
    cycle();
    rst_n = 1'b1;

    // streaming: D2/PF1 one per cycle, D1/PF0 one per two cycles
    p1 = 0; p2 = 0;
    ready_in = 1'b1; credit_in = 1'b1; valid_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      data_in = W'(k + 1);
      if (ro[1]) p1++;
      if (ro[2]) p2++;
      cycle();
      chk($sformatf("stream count1 c%0d", k), cnt[1], 1);
    end
    chk("stream pops D2 PF1", p1, 19);
    chk("stream pops D1 PF0", p2, 10);

    ready_in = 1'b0;
    repeat (5) cycle();

    // wrap-around on the 3-deep link
    wexp = '{{1'b1, 8'ha0}, {1'b0, 8'ha1}, {1'b1, 8'ha2},
             {1'b1, 8'ha3}, {1'b0, 8'ha4}};
    nw = 0;
    for (int k = 0; k < 5; k++) begin
      ready_in = 1'b1; credit_in = 1'b0;
      valid_in = wexp[k][W]; data_in = wexp[k][W-1:0];
      cycle();
      ready_in = 1'b0; credit_in = 1'b1;
      if (ro[3] && nw < 5) begin
        wgot[nw] = {vo[3], dout[3]};
        nw++;
      end
      cycle();
    end
    chk("wrap pop count", nw, 5);
    for (int k = 0; k < 5; k++)
      chk($sformatf("wrap word %0d", k), (k < nw) ? wgot[k] : 'x, wexp[k]);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      ready_in  = 1'($urandom_range(0, 1));
      credit_in = 1'($urandom_range(0, 1));
      valid_in  = 1'($urandom_range(0, 1));
      data_in   = W'($urandom);
      flush     = ($urandom_range(0, 24) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, misc);
    $finish;
  end

endmodule
